// File: rtl/counter_pkg.sv
// Shared types and constants for the scheduled up/down counter datapath.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int CNT_WIDTH = 4;

    // Terminal values: down-counting stops at CNT_MIN, up-counting at CNT_MAX.
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr, cyclically.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDXW-1:0]    idx,
    output logic               vld
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!vld && req[j]) begin
                vld    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/counter_sched_ctrl.sv
// Round-robin scheduler sharing one loadable up/down counter among NUM_REQ requesters.
module counter_sched_ctrl
    import counter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = CNT_WIDTH,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_dir,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     cnt_reset,
    output logic                     cnt_load,
    output logic                     cnt_up_down,
    output logic [WIDTH-1:0]         cnt_data,
    input  logic [WIDTH-1:0]         cnt_count
);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDXW-1:0]      owner_q, owner_d;
    logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 dir_q, dir_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDXW-1:0]      arb_idx;
    logic                 arb_vld;
    logic [WIDTH-1:0]     term;
    logic                 at_term;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign term    = dir_q ? WIDTH'(CNT_MAX) : WIDTH'(CNT_MIN);
    assign at_term = (cnt_count == term);
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        data_d      = data_q;
        dir_d       = dir_q;
        done        = '0;
        cnt_reset   = 1'b0;
        cnt_load    = 1'b0;
        cnt_up_down = 1'b0;
        cnt_data    = '0;
        case (state_q)
            IDLE: begin
                cnt_reset = 1'b1;
                if (arb_vld) begin
                    owner_d = arb_idx;
                    data_d  = req_data[int'(arb_idx)*WIDTH +: WIDTH];
                    dir_d   = req_dir[arb_idx];
                    grant_d = arb_gnt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                cnt_data = data_q;
                state_d  = RUN;
            end
            RUN: begin
                cnt_up_down = dir_q;
                // Reset in the terminal cycle itself so the counter never steps past it.
                if (at_term) begin
                    cnt_reset = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done      = grant_q;
                cnt_reset = 1'b1;
                grant_d   = '0;
                rr_ptr_d  = (owner_q == IDXW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
        end
    end

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Directed bench for counter_sched_ctrl driving a behavioural 4-bit up/down counter.
module tb_counter_sched_ctrl;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_dir;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     cnt_reset;
    logic                     cnt_load;
    logic                     cnt_up_down;
    logic [WIDTH-1:0]         cnt_data;
    logic [WIDTH-1:0]         cnt_count;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit saw_done;

    always #5 clk = ~clk;

    counter_sched_ctrl #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_dir     (req_dir),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .cnt_reset   (cnt_reset),
        .cnt_load    (cnt_load),
        .cnt_up_down (cnt_up_down),
        .cnt_data    (cnt_data),
        .cnt_count   (cnt_count)
    );

    // Counter datapath: reset dominates load, otherwise count in the selected direction.
    always_ff @(posedge clk) begin
        if (cnt_reset)        cnt_count <= '0;
        else if (cnt_load)    cnt_count <= cnt_data;
        else if (cnt_up_down) cnt_count <= cnt_count + 1'b1;
        else                  cnt_count <= cnt_count - 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rst_dut();
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_dir  = '0;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("inv_done_in_grant", 32'(done & ~grant), 32'd0);
            chk("inv_done_busy", 32'((|done) && !busy), 32'd0);
            chk("inv_load_reset", 32'(cnt_load & cnt_reset), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle.
        rst_dut();
        mon_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_cnt_reset", 32'(cnt_reset), 32'd1);
            chk("idle_count", 32'(cnt_count), 32'd0);
        end

        // Requester 1 counts down from 3; req and its data change after the latch.
        req_data[7:4] = 4'd3;
        req_dir       = 4'b0000;
        req           = 4'b0010;
        chk("t2_c0_busy", 32'(busy), 32'd0);
        cyc();
        chk("t2_load_grant", 32'(grant), 32'h2);
        chk("t2_load", 32'(cnt_load), 32'd1);
        chk("t2_load_data", 32'(cnt_data), 32'd3);
        chk("t2_load_rst", 32'(cnt_reset), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk("t2_run_grant", 32'(grant), 32'h2);
            chk("t2_run_count", 32'(cnt_count), 32'(5 - k));
            chk("t2_run_rst", 32'(cnt_reset), 32'(k == 5));
            chk("t2_run_dir", 32'(cnt_up_down), 32'd0);
            chk("t2_run_done", 32'(done), 32'd0);
            chk("t2_run_data0", 32'(cnt_data), 32'd0);
            if (k == 2) begin
                req_data[7:4] = 4'd9;
                req_dir[1]    = 1'b1;
            end
            if (k == 3) req = 4'b0000;
        end
        cyc();
        chk("t2_done", 32'(done), 32'h2);
        chk("t2_done_rst", 32'(cnt_reset), 32'd1);
        chk("t2_done_count", 32'(cnt_count), 32'd0);
        req_data = '0;
        req_dir  = '0;
        req      = 4'b0101;
        cyc();
        chk("t2_after_grant", 32'(grant), 32'd0);
        chk("t2_after_busy", 32'(busy), 32'd0);
        cyc();
        chk("t2_rrptr2_grant", 32'(grant), 32'h4);
        cyc();
        chk("t2b_run_rst", 32'(cnt_reset), 32'd1);
        cyc();
        chk("t2b_done", 32'(done), 32'h4);
        req = 4'b0001;
        cyc();
        chk("t2b_idle_busy", 32'(busy), 32'd0);
        cyc();
        chk("t2c_grant", 32'(grant), 32'h1);

        // Requester 2 counts up from 13.
        rst_dut();
        req_data[11:8] = 4'd13;
        req_dir        = 4'b0100;
        req            = 4'b0100;
        cyc();
        chk("t3_load_grant", 32'(grant), 32'h4);
        chk("t3_load_data", 32'(cnt_data), 32'd13);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            chk("t3_run_count", 32'(cnt_count), 32'(11 + k));
            chk("t3_run_dir", 32'(cnt_up_down), 32'd1);
            chk("t3_run_rst", 32'(cnt_reset), 32'(k == 4));
            chk("t3_run_done", 32'(done), 32'd0);
        end
        cyc();
        chk("t3_done", 32'(done), 32'h4);
        chk("t3_done_count", 32'(cnt_count), 32'd0);
        chk("t3_done_dir", 32'(cnt_up_down), 32'd0);
        req = '0;
        cyc();
        chk("t3_idle_grant", 32'(grant), 32'd0);

        // All four request, all terminal already: grants rotate 0,1,2,3,0.
        rst_dut();
        req = 4'b1111;
        for (int op = 0; op < 5; op++) begin
            cyc();
            chk("t4_load_grant", 32'(grant), 32'(1 << (op % 4)));
            chk("t4_load", 32'(cnt_load), 32'd1);
            cyc();
            chk("t4_run_rst", 32'(cnt_reset), 32'd1);
            chk("t4_run_done", 32'(done), 32'd0);
            cyc();
            chk("t4_done", 32'(done), 32'(1 << (op % 4)));
            if (op == 4) req = '0;
            cyc();
            chk("t4_idle_busy", 32'(busy), 32'd0);
            chk("t4_idle_grant", 32'(grant), 32'd0);
        end

        // Start value already terminal, up then down.
        rst_dut();
        req_data[3:0] = 4'd15;
        req_dir       = 4'b0001;
        req           = 4'b0001;
        cyc();
        chk("t5u_load_grant", 32'(grant), 32'h1);
        cyc();
        chk("t5u_run_count", 32'(cnt_count), 32'd15);
        chk("t5u_run_rst", 32'(cnt_reset), 32'd1);
        cyc();
        chk("t5u_done", 32'(done), 32'h1);
        chk("t5u_count", 32'(cnt_count), 32'd0);
        req           = '0;
        req_data[3:0] = 4'd0;
        req_dir       = 4'b0000;
        cyc();
        req = 4'b0001;
        cyc();
        chk("t5d_load_grant", 32'(grant), 32'h1);
        cyc();
        chk("t5d_run_count", 32'(cnt_count), 32'd0);
        chk("t5d_run_rst", 32'(cnt_reset), 32'd1);
        cyc();
        chk("t5d_done", 32'(done), 32'h1);
        req = '0;

        // Reset in the second RUN cycle of a down-count from 9.
        rst_dut();
        req_data[3:0] = 4'd9;
        req           = 4'b0001;
        cyc();
        chk("t6_load_grant", 32'(grant), 32'h1);
        cyc();
        chk("t6_run1_count", 32'(cnt_count), 32'd9);
        cyc();
        chk("t6_run2_count", 32'(cnt_count), 32'd8);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req   = '0;
        chk("t6_abort_grant", 32'(grant), 32'd0);
        chk("t6_abort_busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            saw_done = saw_done | (|done);
        end
        chk("t6_no_done", 32'(saw_done), 32'd0);
        req = 4'b1001;
        cyc();
        chk("t6_rrptr0_grant", 32'(grant), 32'h1);
        rst_dut();
        req = 4'b1000;
        cyc();
        chk("t6_req3_grant", 32'(grant), 32'h8);
        req = '0;
        repeat (5) cyc();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
